// File: rtl/nonce_dispatch_if.sv
// Job, issue, result and found-nonce signals between the
// nonce dispatcher and its surroundings.
interface nonce_dispatch_if #(
    parameter int NONCE_W = 32
);
    logic               start;
    logic [NONCE_W-1:0] nonce_base;
    logic [NONCE_W-1:0] nonce_count;
    logic               issue_valid;
    logic [NONCE_W-1:0] issue_nonce;
    logic               result_valid;
    logic               result_hit;
    logic               found_valid;
    logic [NONCE_W-1:0] found_nonce;
    logic               found_ready;
    logic               done;
    logic               busy;
    logic               error;

    modport slave (
        input  start, nonce_base, nonce_count,
        input  result_valid, result_hit, found_ready,
        output issue_valid, issue_nonce,
        output found_valid, found_nonce,
        output done, busy, error
    );

    modport master (
        output start, nonce_base, nonce_count,
        output result_valid, result_hit, found_ready,
        input  issue_valid, issue_nonce,
        input  found_valid, found_nonce,
        input  done, busy, error
    );
endinterface

// File: rtl/nonce_dispatch.sv
// Nonce issue engine: credit-limited issue, in-order result
// pairing through an in-flight FIFO, first-hit capture and drain.
module nonce_dispatch #(
    parameter int NONCE_W = 32,
    parameter int DEPTH   = 16
) (
    input logic             clk,
    input logic             rst_n,
    nonce_dispatch_if.slave dif
);
    localparam int         AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FOUND,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [NONCE_W-1:0] next_q;
    logic [NONCE_W-1:0] count_q;
    logic [NONCE_W-1:0] issued_q;
    logic [NONCE_W-1:0] win_q;
    logic [NONCE_W-1:0] issue_nonce_q;
    logic [NONCE_W-1:0] found_nonce_q;
    logic [NONCE_W-1:0] fifo_q [DEPTH];
    logic [AW-1:0]      wr_q;
    logic [AW-1:0]      rd_q;
    logic [AW:0]        inflight_q;
    logic [AW:0]        inflight_d;
    logic               hit_q;
    logic               issue_valid_q;
    logic               found_valid_q;
    logic               done_q;
    logic               error_q;

    logic               pop;
    logic               push;
    logic               hit_now;
    logic               hit_d;
    logic               last_issue;
    logic               to_drain;
    logic               fin;
    logic [NONCE_W-1:0] push_nonce;
    logic [NONCE_W-1:0] win_d;

    assign pop     = dif.result_valid && (inflight_q != '0);
    assign hit_now = pop && dif.result_hit && !hit_q;
    assign hit_d   = hit_q | hit_now;
    assign win_d   = hit_now ? fifo_q[rd_q] : win_q;

    // Issue gating uses inflight before this cycle's pop.
    always_comb begin
        push       = 1'b0;
        push_nonce = next_q;
        unique case (state_q)
            S_IDLE: begin
                push       = dif.start && (dif.nonce_count != '0);
                push_nonce = dif.nonce_base;
            end
            S_ISSUE: begin
                push = !hit_now && (issued_q != count_q)
                    && (inflight_q < FULL);
            end
            default: ;
        endcase
    end

    assign inflight_d = inflight_q + {{AW{1'b0}}, push}
                      - {{AW{1'b0}}, pop};
    assign last_issue = push && (state_q == S_ISSUE)
                     && (issued_q + NONCE_W'(1) == count_q);
    assign to_drain   = (state_q == S_ISSUE) && (hit_now || last_issue);
    assign fin        = (to_drain || state_q == S_DRAIN)
                     && (inflight_d == '0);

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= push_nonce;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            next_q        <= '0;
            count_q       <= '0;
            issued_q      <= '0;
            win_q         <= '0;
            issue_nonce_q <= '0;
            found_nonce_q <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            inflight_q    <= '0;
            hit_q         <= 1'b0;
            issue_valid_q <= 1'b0;
            found_valid_q <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            issue_valid_q <= push;
            if (push) begin
                issue_nonce_q <= push_nonce;
                wr_q          <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            inflight_q <= inflight_d;
            if (dif.result_valid && inflight_q == '0) error_q <= 1'b1;
            if (hit_now) begin
                hit_q <= 1'b1;
                win_q <= win_d;
            end
            done_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (dif.start) begin
                        count_q <= dif.nonce_count;
                        hit_q   <= 1'b0;
                        if (dif.nonce_count != '0) begin
                            next_q   <= dif.nonce_base + NONCE_W'(1);
                            issued_q <= NONCE_W'(1);
                            state_q  <= (dif.nonce_count == NONCE_W'(1))
                                      ? S_DRAIN : S_ISSUE;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (push) begin
                        next_q   <= next_q + NONCE_W'(1);
                        issued_q <= issued_q + NONCE_W'(1);
                    end
                    if (to_drain) state_q <= S_DRAIN;
                end
                S_DRAIN: ;
                S_FOUND: begin
                    if (dif.found_ready) begin
                        found_valid_q <= 1'b0;
                        done_q        <= 1'b1;
                        state_q       <= S_DONE;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // Last pop also ends the job, skipping an idle DRAIN cycle.
            if (fin) begin
                if (hit_d) begin
                    state_q       <= S_FOUND;
                    found_valid_q <= 1'b1;
                    found_nonce_q <= win_d;
                end else begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign dif.issue_valid = issue_valid_q;
    assign dif.issue_nonce = issue_nonce_q;
    assign dif.found_valid = found_valid_q;
    assign dif.found_nonce = found_nonce_q;
    assign dif.done        = done_q;
    assign dif.busy        = (state_q != S_IDLE);
    assign dif.error       = error_q;
endmodule

// File: doc/nonce_dispatch.md
# nonce_dispatch

Issue-side companion to the 256-bit hash/target comparator. Hands out candidate nonces to the hash/compare pipeline, tracks every nonce in flight in an ordered FIFO and pairs each returning compare result with its nonce. On the first hit it stops issuing, drains the pipeline and presents the winning nonce on a valid/ready output.

## Interface
- NONCE_W, 32, nonce and count width
- DEPTH, 16, max nonces in flight; power of two, 2..256

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job start pulse; sampled only in IDLE
- nonce_base  in  NONCE_W  first nonce of the job; latched on start
- nonce_count  in  NONCE_W  number of nonces to try; latched on start; 0 = empty job
- issue_valid  out  1  registered; candidate presented to the pipeline this cycle
- issue_nonce  out  NONCE_W  registered; candidate nonce, valid with issue_valid
- result_valid  in  1  compare result strobe from the comparator's write
- result_hit  in  1  compare result from the comparator's out; qualified by result_valid
- found_valid  out  1  winning nonce available
- found_nonce  out  NONCE_W  winning nonce; stable while found_valid
- found_ready  in  1  consumer accepts found_nonce
- done  out  1  one-cycle pulse at job end
- busy  out  1  high in every state except IDLE
- error  out  1  sticky; result_valid arrived with nothing in flight

## Operation
- The pipeline has no backpressure. It must return exactly one result per issued nonce, in issue order.
- States: IDLE, ISSUE, DRAIN, FOUND, DONE.
- IDLE:
  - start with nonce_count≠0 → latch base and count, clear issued counter → ISSUE.
  - start with nonce_count=0 → DONE.
  - start in any other state is ignored.
- ISSUE:
  - Issue one nonce per cycle while inflight < DEPTH. Nonces are base, base+1, … modulo 2^NONCE_W; wrap is silent.
  - Each issue pushes the nonce into the in-flight FIFO.
  - Go to DRAIN when issued = count, or when a hit is sampled.
- Result handling, every state:
  - result_valid pops the FIFO head.
  - If result_hit=1 and no hit is captured yet for this job, the popped nonce loads found_nonce.
  - Later hits in the same job are discarded.
- inflight counter:
  - +1 on issue, −1 on pop, unchanged when both occur in the same cycle.
  - Capacity is not freed in the same cycle: issue requires inflight < DEPTH before the pop.
- DRAIN: when inflight=0, go to FOUND if a hit was captured, otherwise DONE.
- FOUND: hold found_valid=1 and found_nonce stable until found_ready=1 → DONE.
- DONE: done=1 for one cycle → IDLE.
- result_valid with inflight=0 sets error, causes no pop and no counter change. Only reset clears error.
- Reset values: issue_valid=0, issue_nonce=0, found_valid=0, found_nonce=0, done=0, busy=0, error=0, state=IDLE, FIFO empty, counters 0.
- Reset mid-job abandons the job. Any results still returning after reset set error.

## Timing
- start sampled at edge t → first issue_valid=1 in cycle t+1.
- Back-to-back issue: one nonce per cycle, no bubbles while credit is available.
- Hit sampled at edge h → issue_valid=0 from cycle h+1 onward. The issue already registered at edge h (cycle h) stands and is drained.
- Last pop at edge d → found_valid=1 in cycle d+1, or done=1 in cycle d+1 if there was no hit.
- found_ready high at edge a while found_valid=1 → found_valid=0 and done=1 in cycle a+1.
- Empty job: start at edge t → done=1 in cycle t+1, no issue_valid.
- busy rises the cycle after start is sampled and falls the cycle after the done pulse.

## Test plan
- Miss-only job: base=0x10, count=5, comparator model latency 2, never hits → issue_nonce 0x10..0x14 on 5 consecutive cycles; done pulses once, 1 cycle after the 5th result; found_valid stays 0; error=0.
- Credit limit: DEPTH=4, model latency 10, count=8 → never more than 4 outstanding; issue resumes the cycle after each pop; all 8 issued, done once.
- First hit: base=0x100, count=20, hit on 0x102 and on 0x105 → no issue after the cycle following the 0x102 result; found_nonce=0x102 only after drain; hold found_ready=0 for 5 cycles → found_valid and found_nonce stable; done 1 cycle after ready.
- Wrap: base=0xFFFFFFFE, count=4 → issues 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; a hit on the 3rd returns found_nonce=0x0.
- Spurious and edge cases:
  - result_valid in IDLE → error=1, sticky, no other effect.
  - count=0 → done pulse only.
  - start while busy → ignored.
- Reset mid-job: assert rst_n=0 during ISSUE with 3 in flight → all outputs return to reset values immediately; the next job runs cleanly from its own base.
